// File: rtl/boot_loader.sv
// boot_loader: strobe/ack nibble loader driving the CPU bootloader write port.
// Define BOOT_LOADER_CHECKSUM_EN to accept a trailing XOR checksum nibble.
module boot_loader #(
  parameter int DATA_WIDTH           = 4,
  parameter int MEMORY_ADDRESS_WIDTH = 4,
  parameter int MEMORY_REGISTERS     = 16,
  parameter int SYNC_STAGES          = 2
) (
  input  logic                            clk_i,
  input  logic                            reset_n_i,
  input  logic                            prog_mode_i,
  input  logic                            strobe_i,
  input  logic [DATA_WIDTH-1:0]           data_i,
  output logic                            ack_o,
  output logic                            bl_programm_o,
  output logic [DATA_WIDTH-1:0]           bl_data_o,
  output logic [MEMORY_ADDRESS_WIDTH-1:0] bl_address_o,
  output logic                            bl_write_en_mem_o,
  output logic                            done_o,
  output logic                            error_o
);
  localparam int CW = MEMORY_ADDRESS_WIDTH + 1;
  localparam logic [CW-1:0] FULL = CW'(MEMORY_REGISTERS);
  typedef enum logic [2:0] {
    IDLE, WAIT_STB, WRITE, WAIT_REL,
`ifdef BOOT_LOADER_CHECKSUM_EN
    CHECK,
`endif
    DONE
  } state_t;
  state_t state, state_n;
  logic [SYNC_STAGES:0] sync;
  logic [CW-1:0] cnt;
  logic [DATA_WIDTH-1:0] data_q;
  logic rise, low;
  // top stage is the edge-detector register; release waits on it so ack falls SYNC_STAGES+1 edges after strobe
  assign rise = sync[SYNC_STAGES-1] & ~sync[SYNC_STAGES];
  assign low  = ~sync[SYNC_STAGES];
  always_ff @(posedge clk_i)
    if (!reset_n_i) sync <= '0;
    else sync <= {sync[SYNC_STAGES-1:0], strobe_i};
  always_ff @(posedge clk_i)
    if (!reset_n_i) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:     state_n = WAIT_STB;
      WAIT_STB: state_n = rise ? WRITE : WAIT_STB;
      WRITE:    state_n = WAIT_REL;
`ifdef BOOT_LOADER_CHECKSUM_EN
      WAIT_REL: state_n = !low ? WAIT_REL : cnt == FULL ? CHECK : cnt > FULL ? DONE : WAIT_STB;
      CHECK:    state_n = rise ? WAIT_REL : CHECK;
`else
      WAIT_REL: state_n = !low ? WAIT_REL : cnt == FULL ? DONE : WAIT_STB;
`endif
      default:  state_n = state;
    endcase
    if (!prog_mode_i) state_n = IDLE;
  end
  always_ff @(posedge clk_i)
    if (!reset_n_i) data_q <= '0;
    else if (state == WAIT_STB && rise) data_q <= data_i;
`ifdef BOOT_LOADER_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] csum;
  logic err;
  // the checksum nibble bumps the counter past FULL so WAIT_REL knows to finish
  always_ff @(posedge clk_i)
    if (!reset_n_i || state_n == IDLE) cnt <= '0;
    else if (state == WRITE || (state == CHECK && rise)) cnt <= cnt + 1'b1;
  always_ff @(posedge clk_i)
    if (!reset_n_i || state_n == IDLE) begin
      csum <= '0;
      err  <= 1'b0;
    end else begin
      if (state == WRITE) csum <= csum ^ data_q;
      if (state == CHECK && rise) err <= data_i != csum;
    end
`else
  always_ff @(posedge clk_i)
    if (!reset_n_i || state_n == IDLE) cnt <= '0;
    else if (state == WRITE) cnt <= cnt + 1'b1;
`endif
  always_comb begin
    ack_o             = state == WAIT_REL;
    bl_programm_o     = state != IDLE;
    bl_write_en_mem_o = state == WRITE;
    done_o            = state == DONE;
    bl_data_o         = data_q;
    bl_address_o      = cnt[MEMORY_ADDRESS_WIDTH-1:0];
`ifdef BOOT_LOADER_CHECKSUM_EN
    error_o           = err && state == DONE;
`else
    error_o           = 1'b0;
`endif
  end
endmodule

// File: tb/tb_boot_loader.sv
// tb_boot_loader: randomized directed bench for boot_loader with a queue-based write model.
module tb_boot_loader;
  logic clk = 0, reset_n_i = 0, prog_mode_i = 0, strobe_i = 0;
  logic [3:0] data_i = 0, rd, xsum = 0;
  logic ack_o, bl_programm_o, bl_write_en_mem_o, done_o, error_o;
  logic [3:0] bl_data_o, bl_address_o;
  logic ack_prev = 0, we_prev = 0;
  int cyc = 0, n_chk = 0, n_fail = 0, b2b = 0, words = 0;
  int ack_rise = -1, ack_fall = -1, t_rise = 0, t_fall = 0;
  int wq_a[$], wq_d[$], wq_c[$], exp_a[$], exp_d[$];

  boot_loader dut (
    .clk_i(clk), .reset_n_i(reset_n_i), .prog_mode_i(prog_mode_i), .strobe_i(strobe_i),
    .data_i(data_i), .ack_o(ack_o), .bl_programm_o(bl_programm_o), .bl_data_o(bl_data_o),
    .bl_address_o(bl_address_o), .bl_write_en_mem_o(bl_write_en_mem_o), .done_o(done_o),
    .error_o(error_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bl_write_en_mem_o) begin
      wq_a.push_back(int'(bl_address_o));
      wq_d.push_back(int'(bl_data_o));
      wq_c.push_back(cyc);
      if (we_prev) b2b++;
    end
    if (ack_o && !ack_prev) ack_rise = cyc;
    if (!ack_o && ack_prev) ack_fall = cyc;
    ack_prev = ack_o;
    we_prev = bl_write_en_mem_o;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] d, input int hold);
    ack_rise = -1;
    ack_fall = -1;
    tick();
    data_i = d;
    strobe_i = 1;
    t_rise = cyc + 1;
    repeat (hold) tick();
    strobe_i = 0;
    t_fall = cyc + 1;
    repeat (5 + $urandom_range(0, 2)) tick();
  endtask

  task automatic load(input logic [3:0] d, input int hold);
    send(d, hold);
    if (words < 16) begin
      exp_a.push_back(words);
      exp_d.push_back(int'(d));
      xsum ^= d;
      words++;
    end
    chk("ack_rise_lat", ack_rise - t_rise, 3);
    chk("ack_fall_lat", ack_fall - t_fall, 3);
  endtask

  task automatic check_writes(input string tag);
    chk({tag, "_count"}, wq_a.size(), exp_a.size());
    for (int i = 0; i < exp_a.size() && i < wq_a.size(); i++) begin
      chk({tag, "_addr"}, wq_a[i], exp_a[i]);
      chk({tag, "_data"}, wq_d[i], exp_d[i]);
    end
    wq_a.delete(); wq_d.delete(); wq_c.delete(); exp_a.delete(); exp_d.delete();
  endtask

  task automatic finish_image(input logic [3:0] cs);
`ifdef BOOT_LOADER_CHECKSUM_EN
    send(cs, $urandom_range(4, 6));
    chk("cs_ack_rise", ack_rise - t_rise, 3);
`else
    chk("cs_unused", int'(cs), int'(xsum));
`endif
  endtask

  task automatic start();
    tick();
    prog_mode_i = 1;
    chk("prog_pre", bl_programm_o, 0);
    tick();
    chk("prog_rise", bl_programm_o, 1);
    words = 0;
    xsum = 0;
    wq_a.delete(); wq_d.delete(); wq_c.delete(); exp_a.delete(); exp_d.delete();
  endtask

  task automatic stop();
    tick();
    prog_mode_i = 0;
    chk("prog_hold", bl_programm_o, 1);
    tick();
    chk("prog_fall", bl_programm_o, 0);
    chk("idle_done", done_o, 0);
    chk("idle_ack", ack_o, 0);
    chk("idle_addr", bl_address_o, 0);
    chk("idle_err", error_o, 0);
  endtask

  initial begin
    prog_mode_i = 1;
    strobe_i = 1;
    repeat (3) begin
      tick();
      chk("reset_outs", {ack_o, bl_programm_o, bl_data_o, bl_address_o, bl_write_en_mem_o, done_o, error_o}, 0);
    end
    reset_n_i = 1;
    prog_mode_i = 0;
    strobe_i = 0;
    repeat (5) tick();
    chk("reset_nowrite", wq_a.size(), 0);

    start();
    for (int k = 0; k < 16; k++) load(4'(k), $urandom_range(4, 7));
    finish_image(xsum);
    check_writes("img");
    chk("img_done", done_o, 1);
    chk("img_prog", bl_programm_o, 1);
    chk("img_err", error_o, 0);

    send(4'($urandom), 5);
    chk("done_nowrite", wq_a.size(), 0);
    chk("done_noack", ack_rise, -1);
    chk("done_stays", done_o, 1);
    stop();

    start();
    rd = 4'($urandom);
    load(rd, 20);
    chk("hold_wr_lat", wq_c.size() > 0 ? wq_c[0] - t_rise : -1, 2);
    for (int k = 0; k < 4; k++) load(4'($urandom), $urandom_range(4, 8));
    check_writes("pre_abort");
    stop();

    start();
    for (int k = 0; k < 16; k++) load(4'($urandom), $urandom_range(4, 8));
    finish_image(xsum);
    check_writes("restart");
    chk("restart_done", done_o, 1);
    chk("no_b2b", b2b, 0);
    stop();

`ifdef BOOT_LOADER_CHECKSUM_EN
    start();
    for (int k = 1; k <= 16; k++) load(4'(k), 5);
    send(4'h0, 5);
    check_writes("cs_good");
    chk("cs_good_done", done_o, 1);
    chk("cs_good_err", error_o, 0);
    stop();
    start();
    for (int k = 1; k <= 16; k++) load(4'(k), 5);
    send(4'h5, 5);
    check_writes("cs_bad");
    chk("cs_bad_done", done_o, 1);
    chk("cs_bad_err", error_o, 1);
    stop();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
